bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/adder_pkg.sv | 13 +
 rtl/bit_serial_adder_fa_bit.sv | 14 +
 rtl/bit_serial_adder.sv | 95 +++++++++
 tb/tb_bit_serial_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_adder_fa_bit.sv
// Single-bit full adder, pure dataflow.
// Ports: a, b, c in; s = a^b^c, co = majority(a,b,c).
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder step per cycle, LSB first.
// Ports: clk, rst_n, in_valid/in_ready + a, b, cin in; out_valid/out_ready + sum, cout out.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             release_hs;
  logic             last;

  // Handshake outputs are forced low while reset is held.
  assign in_ready   = rst_n && (state == IDLE);
  assign out_valid  = rst_n && (state == DONE);
  assign accept     = in_valid && in_ready;
  assign release_hs = out_valid && out_ready;
  assign last       = (cnt == CW'(WIDTH - 1));

  assign sum  = sum_q;
  assign cout = c_q;

  fa_bit u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (c_q),
    .s  (fa_s),
    .co (fa_c)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = SHIFT;
      SHIFT:   if (last) state_n = DONE;
      DONE:    if (release_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sum_q <= '0;
      c_q   <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      // Sum bits enter at the MSB; after WIDTH shifts bit 0 lands at the LSB.
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      sum_q <= {fa_s, sum_q[WIDTH-1:1]};
      c_q   <= fa_c;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8).
// Directed corner cases plus random traffic against an arithmetic model.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ref_add(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Accept one operand set, wait for the result, hold it for `hold`
  // cycles of back-pressure, then release it.
  task automatic txn(input string tag, input logic [7:0] x,
                     input logic [7:0] y, input logic c, input int hold);
    int lat;
    logic [8:0] r;
    r = ref_add(x, y, c);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_sum"}, 32'(sum), 32'(r[7:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(r[8]));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_s"}, {23'd0, cout, sum}, {23'd0, r});
      chk({tag, "_hold_ir"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_v"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_ir"}, 32'(in_ready), 32'd1);
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] r;
  int sent;
  int got;
  int cyc;
  int lat;
  logic acc;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b0;

    repeat (3) tick();
    chk("rst_ir", 32'(in_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ir", 32'(in_ready), 32'd1);
    tick();

    txn("d0f01", 8'h0F, 8'h01, 1'b0, 0);
    txn("dff01", 8'hFF, 8'h01, 1'b0, 0);
    txn("dffff1", 8'hFF, 8'hFF, 1'b1, 0);
    txn("bp5", 8'h3C, 8'h5A, 1'b1, 5);

    // Operand offered mid-SHIFT must be ignored.
    r = ref_add(8'h01, 8'h01, 1'b0);
    in_valid = 1'b1;
    a = 8'h01;
    b = 8'h01;
    cin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    a = 8'hAA;
    b = 8'h00;
    tick();
    in_valid = 1'b0;
    lat = 3;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd8);
    chk("ign_sum", {23'd0, cout, sum}, {23'd0, r});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (4) tick();
    chk("ign_idle_ir", 32'(in_ready), 32'd1);
    chk("ign_idle_ov", 32'(out_valid), 32'd0);

    // Reset in the middle of SHIFT, counter at 3.
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'h11;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_ir", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rel_ir", 32'(in_ready), 32'd1);
    acc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) acc = 1'b1;
      tick();
    end
    chk("mid_rst_no_ov", 32'(acc), 32'd0);
    txn("post_rst", 8'h10, 8'h20, 1'b0, 0);

    // Random back-to-back traffic with random back-pressure.
    sent = 0;
    got = 0;
    cyc = 0;
    in_valid = 1'b1;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
    while (got < 1000 && cyc < 60000) begin
      out_ready = 1'($urandom);
      if (out_valid) begin
        chk("rnd_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (out_ready && exp_q.size() != 0) begin
          r = exp_q.pop_front();
          chk("rnd_res", {23'd0, cout, sum}, {23'd0, r});
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(ref_add(a, b, cin));
        sent++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (sent < 1000) begin
          a = 8'($urandom);
          b = 8'($urandom);
          cin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("rnd_count", 32'(got), 32'd1000);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
